// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst reader for a 1-cycle-latency sync ROM, streams words out with backpressure
// Optional feature macro: CHECKSUM_EN adds checksum_o, the XOR of all beats accepted in the current burst.
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_m1_i,
    output logic              rom_enable_o,
    output logic [ADDR_W-1:0] rom_address_o,
    input  logic [DATA_W-1:0] rom_read_data_i,
`ifdef CHECKSUM_EN
    output logic [DATA_W-1:0] checksum_o,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issue_cnt_q;
    logic [ADDR_W-1:0] beat_cnt_q;
    logic              inflight_q;
    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              done_q;

    logic       start_acc;
    logic       pop;
    logic       push;
    logic       issue;
    logic       last_beat;
    logic [1:0] occ_eff;
    logic [1:0] credit_used;

    // Handshake decode and read-credit accounting; a beat leaving this cycle frees its slot immediately
    // so a held-high out_ready sustains one beat per cycle.
    always_comb begin
        start_acc   = (state_q == S_IDLE) && start_i;
        pop         = (count_q != 2'd0) && out_ready_i;
        push        = inflight_q;
        occ_eff     = count_q - {1'b0, pop};
        credit_used = occ_eff + {1'b0, inflight_q};
        issue       = (state_q == S_RUN) && (credit_used < 2'd2);
        last_beat   = pop && (beat_cnt_q == len_q);
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Burst sequencing: IDLE -> RUN while reads remain -> DRAIN until the final beat leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (issue && (issue_cnt_q == len_q)) state_d = S_DRAIN;
            S_DRAIN: if (last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and the one-cycle completion pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_beat;
        end
    end

    // Read issue side: burst parameters, next address (wraps naturally) and the last driven address.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            next_addr_q <= '0;
            last_addr_q <= '0;
            issue_cnt_q <= '0;
            len_q       <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (start_acc) begin
                next_addr_q <= base_addr_i;
                issue_cnt_q <= '0;
                len_q       <= len_m1_i;
            end else if (issue) begin
                last_addr_q <= next_addr_q;
                next_addr_q <= next_addr_q + 1'b1;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
        end
    end

    // Two-entry output FIFO; the credit rule guarantees a push never finds it full.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rom_read_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Beat counter for the output side; identifies the last beat of the burst.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_cnt_q <= '0;
        end else if (start_acc) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Running XOR of accepted beats, restarted on every accepted start.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q ^ mem_q[rd_ptr_q];
        end
    end

    assign checksum_o = csum_q;
`endif

    assign rom_enable_o  = issue;
    assign rom_address_o = issue ? next_addr_q : last_addr_q;
    assign out_valid_o   = (count_q != 2'd0);
    assign out_data_o    = mem_q[rd_ptr_q];
    assign out_last_o    = (count_q != 2'd0) && (beat_cnt_q == len_q);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;

endmodule
